vscale_dmem_wb_responder: RTL and testbench



---
 rtl/vscale_dmem_wb_responder_pkg.sv | 21 ++
 rtl/vscale_dmem_sel_gen.sv | 15 +
 rtl/vscale_dmem_wb_responder.sv | 80 ++++++++
 tb/tb_vscale_dmem_wb_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vscale_dmem_wb_responder_pkg.sv
// vscale_dmem_wb_responder_pkg: memory-type codes, responder states and byte-select helper.
package vscale_dmem_wb_responder_pkg;

    localparam int MEM_TYPE_WIDTH = 3;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB = 3'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH = 3'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_FAULT = 2'd2
    } dmem_state_e;

    // Any size code other than SB/SH selects the whole word.
    function automatic logic [3:0] byte_sel(input logic [MEM_TYPE_WIDTH-1:0] size, input logic [1:0] addr_lo);
        return size == MEM_TYPE_SB ? 4'b0001 << addr_lo :
               size == MEM_TYPE_SH ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
    endfunction

endpackage

// File: rtl/vscale_dmem_sel_gen.sv
// vscale_dmem_sel_gen: size/address to Wishbone byte selects and misalignment flag.
module vscale_dmem_sel_gen
    import vscale_dmem_wb_responder_pkg::*;
(
    input  logic [MEM_TYPE_WIDTH-1:0] size,
    input  logic [1:0]                addr_lo,
    output logic [3:0]                sel,
    output logic                      misaligned
);

    assign sel        = byte_sel(size, addr_lo);
    assign misaligned = size == MEM_TYPE_SB ? 1'b0 :
                        size == MEM_TYPE_SH ? addr_lo[0] : |addr_lo;

endmodule

// File: rtl/vscale_dmem_wb_responder.sv
// vscale_dmem_wb_responder: turns vscale pipeline data-memory requests into classic Wishbone cycles.
module vscale_dmem_wb_responder
    import vscale_dmem_wb_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [31:0]               dmem_addr,
    input  logic [31:0]               dmem_wdata_delayed,
    output logic [31:0]               dmem_rdata,
    output logic                      dmem_wait,
    output logic                      dmem_badmem_e,
    output logic [31:0]               wb_adr_o,
    output logic [31:0]               wb_dat_o,
    output logic [3:0]                wb_sel_o,
    output logic                      wb_we_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    input  logic [31:0]               wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    dmem_state_e state;
    logic [15:0] cnt;
    logic [31:0] rdata_hold;
    logic [3:0]  sel;
    logic        mis, bus, timeout, term, accept;

    vscale_dmem_sel_gen u_sel (
        .size       (dmem_size),
        .addr_lo    (dmem_addr[1:0]),
        .sel        (sel),
        .misaligned (mis)
    );

    assign bus           = state == ST_BUS;
    assign timeout       = bus & (cnt == TO_LAST);
    assign term          = wb_ack_i | wb_err_i | timeout;
    assign dmem_wait     = bus & ~term;
    assign dmem_badmem_e = (state == ST_FAULT) | (bus & (wb_err_i | timeout));
    assign dmem_rdata    = (bus & wb_ack_i) ? wb_dat_i : rdata_hold;
    assign accept        = dmem_en & ~dmem_wait;
    assign wb_cyc_o      = bus;
    assign wb_stb_o      = bus;
    assign wb_dat_o      = bus ? dmem_wdata_delayed : 32'd0;

    // A new request may be taken on the same edge that ends the current one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 16'd0;
            rdata_hold <= 32'd0;
            wb_adr_o   <= 32'd0;
            wb_sel_o   <= 4'd0;
            wb_we_o    <= 1'b0;
        end else begin
            if (accept) begin
                state    <= mis ? ST_FAULT : ST_BUS;
                cnt      <= 16'd0;
                wb_adr_o <= {dmem_addr[31:2], 2'b00};
                wb_sel_o <= sel;
                wb_we_o  <= dmem_wen;
            end else if (!dmem_wait) begin
                state <= ST_IDLE;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
            if (bus & wb_ack_i)
                rdata_hold <= wb_dat_i;
        end
    end

endmodule

// File: tb/tb_vscale_dmem_wb_responder.sv
// tb_vscale_dmem_wb_responder: directed and randomized checks of the dmem Wishbone responder.
module tb_vscale_dmem_wb_responder;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dmem_en = 1'b0, dmem_wen = 1'b0;
    logic [2:0]  dmem_size = 3'd0;
    logic [31:0] dmem_addr = 32'd0, dmem_wdata_delayed = 32'd0;
    logic [31:0] dmem_rdata, wb_adr_o, wb_dat_o;
    logic        dmem_wait, dmem_badmem_e, wb_we_o, wb_cyc_o, wb_stb_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

    int tests = 0, fails = 0;
    logic [31:0] exp_hold = 32'd0;

    vscale_dmem_wb_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
        .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait),
        .dmem_badmem_e(dmem_badmem_e), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " cyc"}, 32'(wb_cyc_o), 32'd0);
        check({tag, " stb"}, 32'(wb_stb_o), 32'd0);
        check({tag, " wait"}, 32'(dmem_wait), 32'd0);
        check({tag, " bad"}, 32'(dmem_badmem_e), 32'd0);
        check({tag, " rdata"}, dmem_rdata, exp_hold);
    endtask

    // kind: 0 = ACK after w wait states, 1 = ERR after w (optionally with ACK), 2 = silent slave.
    task automatic do_access(input string tag, input logic wen, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdat,
                             input int w, input int kind, input logic both);
        int n, base, t;
        logic [3:0] esel;
        logic mis, ackk, errk;
        n = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
        mis = (addr % n) != 0;
        base = (int'(addr % 4) / n) * n;
        esel = 4'(((1 << n) - 1) << base);
        t = (kind == 2) ? TO - 1 : w;
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = wen; dmem_size = size; dmem_addr = addr;
        dmem_wdata_delayed = $urandom;
        @(posedge clk); #1;
        dmem_en = 1'b0; dmem_wdata_delayed = wdata;
        if (mis) begin
            #1;
            check({tag, " fault cyc"}, 32'(wb_cyc_o), 32'd0);
            check({tag, " fault bad"}, 32'(dmem_badmem_e), 32'd1);
            check({tag, " fault wait"}, 32'(dmem_wait), 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k <= t; k++) begin
                ackk = (k == w) && (kind == 0 || (kind == 1 && both));
                errk = (k == w) && (kind == 1);
                wb_ack_i = ackk; wb_err_i = errk;
                wb_dat_i = ackk ? rdat : $urandom;
                #1;
                check({tag, " cyc"}, 32'(wb_cyc_o), 32'd1);
                check({tag, " stb"}, 32'(wb_stb_o), 32'd1);
                check({tag, " adr"}, wb_adr_o, {addr[31:2], 2'b00});
                check({tag, " sel"}, 32'(wb_sel_o), 32'(esel));
                check({tag, " we"}, 32'(wb_we_o), 32'(wen));
                check({tag, " dat_o"}, wb_dat_o, wdata);
                check({tag, " wait"}, 32'(dmem_wait), 32'(k < t));
                check({tag, " bad"}, 32'(dmem_badmem_e), 32'(k == t && kind != 0));
                check({tag, " rdata"}, dmem_rdata, ackk ? rdat : exp_hold);
                if (ackk) exp_hold = rdat;
                @(posedge clk); #1;
            end
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        check_idle({tag, " after"});
    endtask

    initial begin
        #2;
        check("reset cyc", 32'(wb_cyc_o), 32'd0);
        check("reset adr", wb_adr_o, 32'd0);
        check("reset sel", 32'(wb_sel_o), 32'd0);
        check("reset we", 32'(wb_we_o), 32'd0);
        check("reset dat_o", wb_dat_o, 32'd0);
        check_idle("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        do_access("lw100", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        do_access("sb203", 1'b1, 3'd0, 32'h203, 32'h5A5A5A5A, 32'h0, 2, 0, 1'b0);
        do_access("sh301", 1'b1, 3'd1, 32'h301, 32'h0, 32'h0, 0, 0, 1'b0);
        do_access("sw302", 1'b1, 3'd2, 32'h302, 32'h0, 32'h0, 0, 0, 1'b0);
        do_access("lw_err", 1'b0, 3'd2, 32'h400, 32'h0, 32'h12345678, 2, 1, 1'b1);
        do_access("lw_to", 1'b0, 3'd2, 32'h500, 32'h0, 32'h0, 0, 2, 1'b0);

        // Back-to-back LW 0, SW 4, LW 8 against a zero-wait slave.
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            wb_ack_i = 1'b1; wb_dat_i = 32'hA000 + 32'(i);
            dmem_wdata_delayed = 32'hC000 + 32'(i);
            dmem_en = i < 2; dmem_wen = i == 0; dmem_addr = 32'(4 * (i + 1));
            #1;
            check("b2b cyc", 32'(wb_cyc_o), 32'd1);
            check("b2b adr", wb_adr_o, 32'(4 * i));
            check("b2b we", 32'(wb_we_o), 32'(i == 1));
            check("b2b wait", 32'(dmem_wait), 32'd0);
            check("b2b rdata", dmem_rdata, 32'hA000 + 32'(i));
            exp_hold = 32'hA000 + 32'(i);
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0; dmem_en = 1'b0;
        #1;
        check_idle("b2b end");

        // Reset in the middle of the second access of a pair.
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h0;
        @(posedge clk); #1;
        wb_ack_i = 1'b1; wb_dat_i = 32'h77; dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h4;
        @(posedge clk); #1;
        wb_ack_i = 1'b0; dmem_en = 1'b0;
        #1;
        check("mid cyc", 32'(wb_cyc_o), 32'd1);
        check("mid wait", 32'(dmem_wait), 32'd1);
        reset = 1'b0;
        #1;
        exp_hold = 32'd0;
        check("areset cyc", 32'(wb_cyc_o), 32'd0);
        check("areset adr", wb_adr_o, 32'd0);
        check("areset sel", 32'(wb_sel_o), 32'd0);
        check("areset we", 32'(wb_we_o), 32'd0);
        check("areset dat_o", wb_dat_o, 32'd0);
        check_idle("areset");
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < 60; r++) begin
            do_access("rand", 1'($urandom), 3'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
